// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and memory-side bus of the memory arbiter
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_valid;
  logic                  dm_read;
  logic                  dm_write;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic [2:0]            dm_mode;
  logic [DATA_WIDTH-1:0] dm_rdata;
  logic                  dm_valid;
  logic                  stall;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [2:0]            mem_mode;
  logic [DATA_WIDTH-1:0] mem_rdata;
  modport master (
    input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, dm_mode, mem_rdata,
    output if_rdata, if_valid, dm_rdata, dm_valid, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_mode
  );
  modport slave (
    output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, dm_mode, mem_rdata,
    input  if_rdata, if_valid, dm_rdata, dm_valid, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_mode
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data (data first), stalling until all accesses finish
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input logic           clk,
  input logic           rst_n,
  mem_arbiter_if.master bus
);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t                state_q, state_d;
  logic                  d_pend_q, d_pend_d, i_pend_q, i_pend_d;
  logic                  sel_q, sel_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]            mem_mode_q, mem_mode_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic                  any_req, other;
  logic                  stall;
  assign any_req = bus.if_req | bus.dm_read | bus.dm_write;
  assign other   = sel_q ? i_pend_q : d_pend_q;
  assign bus.stall     = stall;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_mode  = mem_mode_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_valid  = (state_q == DONE) & ~sel_q;
  assign bus.dm_valid  = (state_q == DONE) & sel_q;
  // Next state, pending flags, counter, read capture and the one-cycle memory strobe (sel = 1 means data port)
  always_comb begin
    state_d     = state_q;
    d_pend_d    = d_pend_q;
    i_pend_d    = i_pend_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_mode_d  = mem_mode_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    stall       = 1'b0;
    case (state_q)
      IDLE: begin
        stall = any_req;
        if (any_req) begin
          d_pend_d = bus.dm_read | bus.dm_write;
          i_pend_d = bus.if_req;
          sel_d    = bus.dm_read | bus.dm_write;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        stall   = 1'b1;
        cnt_d   = CW'(LATENCY);
        state_d = mem_we_q ? DONE : WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          if_rdata_d = sel_q ? if_rdata_q : bus.mem_rdata;
          dm_rdata_d = sel_q ? bus.mem_rdata : dm_rdata_q;
          state_d    = DONE;
        end
      end
      DONE: begin
        stall    = other;
        d_pend_d = sel_q ? 1'b0 : d_pend_q;
        i_pend_d = sel_q ? i_pend_q : 1'b0;
        sel_d    = other ? ~sel_q : sel_q;
        state_d  = other ? ISSUE : IDLE;
      end
    endcase
    if (state_d == ISSUE) begin
      mem_req_d   = 1'b1;
      mem_we_d    = sel_d & bus.dm_write;
      mem_addr_d  = sel_d ? bus.dm_addr : bus.if_addr;
      mem_wdata_d = sel_d ? bus.dm_wdata : mem_wdata_q;
      mem_mode_d  = sel_d ? bus.dm_mode : 3'b010;
    end
  end
  // State and output registers; reset abandons any in-flight access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      d_pend_q    <= 1'b0;
      i_pend_q    <= 1'b0;
      sel_q       <= 1'b0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_mode_q  <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      d_pend_q    <= d_pend_d;
      i_pend_q    <= i_pend_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mode_q  <= mem_mode_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, corner sequences and random transactions against a timing model
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_if = '0;
  logic [31:0] exp_dm = '0;
  mem_arbiter_if b0();
  mem_arbiter_if b1();
  mem_arbiter u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  mem_arbiter #(.LATENCY(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  always #5 clk = ~clk;
  typedef struct {
    logic rd, wr, ir;
    logic [31:0] da, wd, ia, dval, ival;
    logic [2:0] mode;
    int di, dd, ii, idn, en;
  } vec_t;
  vec_t tbl[7];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // Timing model with LATENCY 2: data first, each access issue+1 (write) or issue+3 (read) to DONE
  task automatic model(input logic rd, wr, ir, output int di, dd, ii, idn, en);
    int t;
    t = 1; di = -1; dd = -1; ii = -1; idn = -1;
    if (rd || wr) begin di = t; dd = t + (wr ? 1 : 3); t = dd + 1; end
    if (ir) begin ii = t; idn = t + 3; t = idn + 1; end
    en = (rd || wr || ir) ? t - 1 : 0;
  endtask
  // Drives one request at cycle 0 (an IDLE cycle) and checks every cycle through the final DONE
  task automatic run_txn(input vec_t v);
    logic ld;
    ld = v.rd && !v.wr;
    b0.dm_read = v.rd; b0.dm_write = v.wr; b0.if_req = v.ir;
    b0.dm_addr = v.da; b0.dm_wdata = v.wd; b0.dm_mode = v.mode; b0.if_addr = v.ia;
    for (int k = 0; k <= v.en; k++) begin
      b0.mem_rdata = (ld && v.di >= 0 && k == v.di + 2) ? v.dval : (v.ir && k == v.ii + 2) ? v.ival : $urandom;
      #1;
      chk("stall", 32'(b0.stall), 32'(k < v.en));
      chk("mem_req", 32'(b0.mem_req), 32'(k == v.di || k == v.ii));
      chk("dm_valid", 32'(b0.dm_valid), 32'(k == v.dd));
      chk("if_valid", 32'(b0.if_valid), 32'(k == v.idn));
      if (k == v.di) begin
        chk("d_addr", b0.mem_addr, v.da);
        chk("d_we", 32'(b0.mem_we), 32'(v.wr));
        chk("d_mode", 32'(b0.mem_mode), 32'(v.mode));
        if (v.wr) chk("d_wdata", b0.mem_wdata, v.wd);
      end
      if (k == v.ii) begin
        chk("i_addr", b0.mem_addr, v.ia);
        chk("i_we", 32'(b0.mem_we), 32'd0);
        chk("i_mode", 32'(b0.mem_mode), 32'd2);
      end
      chk("if_rdata", b0.if_rdata, (v.ir && k >= v.idn) ? v.ival : exp_if);
      chk("dm_rdata", b0.dm_rdata, (ld && k >= v.dd) ? v.dval : exp_dm);
      @(negedge clk);
    end
    if (v.ir) exp_if = v.ival;
    if (ld) exp_dm = v.dval;
  endtask
  initial begin
    vec_t v;
    logic hold;
    tbl[0] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h100, 32'h0, 32'h00500093, 3'b000, -1, -1, 1, 4, 4};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h2000, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 3'b111, 1, 2, -1, -1, 2};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 32'h3004, 32'h0, 32'h104, 32'h12345678, 32'h00A00113, 3'b010, 1, 4, 5, 8, 8};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h40, 32'h55AA55AA, 32'h108, 32'hBAD0BAD0, 32'h11111111, 3'b001, 1, 2, 3, 6, 6};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, -1, -1, -1, -1, 0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 32'h0, 32'hCAFEF00D, 32'h0, 3'b100, 1, 4, -1, -1, 4};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 32'h0, 32'h0BADF00D, 32'h0, 3'b100, 1, 4, -1, -1, 4};
    b0.if_req = 0; b0.dm_read = 0; b0.dm_write = 0; b0.if_addr = 0; b0.dm_addr = 0;
    b0.dm_wdata = 0; b0.dm_mode = 0; b0.mem_rdata = 0;
    b1.if_req = 0; b1.dm_read = 0; b1.dm_write = 0; b1.if_addr = 0; b1.dm_addr = 0;
    b1.dm_wdata = 0; b1.dm_mode = 0; b1.mem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(b0.stall), 32'd0);
    chk("rst_mem_req", 32'(b0.mem_req), 32'd0);
    chk("rst_mem_addr", b0.mem_addr, 32'd0);
    chk("rst_if_rdata", b0.if_rdata, 32'd0);
    chk("rst_valids", 32'({b0.if_valid, b0.dm_valid}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) run_txn(tbl[i]);
    // Reset asserted mid-WAIT of a load: everything clears at once and the stale data is never captured
    b0.dm_read = 1; b0.dm_write = 0; b0.if_req = 0; b0.dm_addr = 32'h77; b0.dm_mode = 3'b010;
    repeat (2) @(negedge clk);
    b0.dm_read = 0; rst_n = 1'b0;
    #1;
    chk("mid_rst_mem", 32'({b0.mem_req, b0.mem_we, b0.mem_mode}), 32'd0);
    chk("mid_rst_addr", b0.mem_addr, 32'd0);
    chk("mid_rst_wdata", b0.mem_wdata, 32'd0);
    chk("mid_rst_if_rdata", b0.if_rdata, 32'd0);
    chk("mid_rst_dm_rdata", b0.dm_rdata, 32'd0);
    chk("mid_rst_out", 32'({b0.stall, b0.if_valid, b0.dm_valid}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_if = '0; exp_dm = '0;
    for (int k = 0; k < 4; k++) begin
      b0.mem_rdata = 32'h5A5A5A5A;
      @(negedge clk);
      chk("stale_dm_rdata", b0.dm_rdata, 32'd0);
      chk("stale_out", 32'({b0.mem_req, b0.dm_valid, b0.stall}), 32'd0);
    end
    // LATENCY 1: a load completes at T+3, a read+write pair behaves as a write
    b1.dm_read = 1; b1.dm_addr = 32'h10; b1.dm_mode = 3'b010;
    for (int k = 0; k <= 3; k++) begin
      b1.mem_rdata = (k == 2) ? 32'hCAFE0001 : $urandom;
      #1;
      chk("l1_stall", 32'(b1.stall), 32'(k < 3));
      chk("l1_mem_req", 32'(b1.mem_req), 32'(k == 1));
      chk("l1_dm_valid", 32'(b1.dm_valid), 32'(k == 3));
      chk("l1_dm_rdata", b1.dm_rdata, (k == 3) ? 32'hCAFE0001 : 32'd0);
      @(negedge clk);
    end
    b1.dm_write = 1; b1.dm_wdata = 32'h0F0F0F0F;
    for (int k = 0; k <= 2; k++) begin
      b1.mem_rdata = $urandom;
      #1;
      chk("l1w_stall", 32'(b1.stall), 32'(k < 2));
      chk("l1w_req_we", 32'({b1.mem_req, b1.mem_we}), (k == 1) ? 32'd3 : (k == 0) ? 32'd0 : 32'(b1.mem_we));
      chk("l1w_dm_valid", 32'(b1.dm_valid), 32'(k == 2));
      chk("l1w_dm_rdata", b1.dm_rdata, 32'hCAFE0001);
      @(negedge clk);
    end
    b1.dm_read = 0; b1.dm_write = 0;
    // Random transactions, sometimes holding the previous request across DONE into the next IDLE
    v = tbl[4];
    for (int n = 0; n < 150; n++) begin
      hold = (n > 0) && ($urandom_range(0, 9) < 3);
      if (!hold) begin
        v.rd = 1'($urandom_range(0, 1));
        v.wr = ($urandom_range(0, 2) == 0);
        v.ir = 1'($urandom_range(0, 1));
        v.da = $urandom; v.wd = $urandom; v.ia = $urandom;
        v.mode = 3'($urandom_range(0, 7));
      end
      v.dval = $urandom; v.ival = $urandom;
      model(v.rd, v.wr, v.ir, v.di, v.dd, v.ii, v.idn, v.en);
      run_txn(v);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
